// File: rtl/log_motion_ctrl.sv
// River log position generator: holds every log's top-left corner and steps each lane
// once per FRAME_DIV frames in a one-log-per-cycle sweep started by startOfFrame.
module log_motion_ctrl #(
    parameter int unsigned NUM_LANES     = 5,
    parameter int unsigned LOGS_PER_LANE = 3,
    parameter int unsigned OUT_SLOTS     = 100,
    parameter int unsigned SCREEN_W      = 640,
    parameter int unsigned LANE0_Y       = 80,
    parameter int unsigned LANE_PITCH    = 20,
    parameter int unsigned LANE_STAGGER  = 40,
    parameter int unsigned FRAME_DIV     = 2
) (
    input  logic        CLK,
    input  logic        RESETn,
    input  logic        startOfFrame,
    input  logic        enable,
    input  logic        restart,
    input  logic [1:0]  level,
    output logic [10:0] ObjectStartX [OUT_SLOTS],
    output logic [10:0] ObjectStartY [OUT_SLOTS],
    output logic        busy,
    output logic        update_done
);

    localparam int unsigned NUM_ACTIVE = NUM_LANES * LOGS_PER_LANE;
    localparam int unsigned IDX_W  = (NUM_ACTIVE > 1)    ? $clog2(NUM_ACTIVE)    : 1;
    localparam int unsigned LANE_W = (NUM_LANES > 1)     ? $clog2(NUM_LANES)     : 1;
    localparam int unsigned LOG_W  = (LOGS_PER_LANE > 1) ? $clog2(LOGS_PER_LANE) : 1;
    localparam int unsigned FRM_W  = (FRAME_DIV > 1)     ? $clog2(FRAME_DIV)     : 1;
    localparam int unsigned POS_W  = 11;
    localparam int unsigned ARI_W  = 12;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SWEEP = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [FRM_W-1:0]    frame_q, frame_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic [LANE_W-1:0]   lane_q, lane_d;
    logic [LOG_W-1:0]    log_q, log_d;
    logic                busy_d, done_d;
    logic                wr_en_c;
    logic [ARI_W-1:0]    step_c, cur_c, sum_c, x_new_c;
    logic [POS_W-1:0]    pos_x [NUM_ACTIVE];
    logic [POS_W-1:0]    pos_y [NUM_ACTIVE];

    function automatic logic [POS_W-1:0] init_x(input int unsigned slot);
        int unsigned l;
        int unsigned k;
        l = slot / LOGS_PER_LANE;
        k = slot % LOGS_PER_LANE;
        return POS_W'((k * (SCREEN_W / LOGS_PER_LANE) + l * LANE_STAGGER) % SCREEN_W);
    endfunction

    function automatic logic [POS_W-1:0] init_y(input int unsigned slot);
        return POS_W'(LANE0_Y + (slot / LOGS_PER_LANE) * LANE_PITCH);
    endfunction

    // State and sweep-counter registers
    always_ff @(posedge CLK or negedge RESETn) begin
        if (!RESETn) begin
            state_q     <= IDLE;
            frame_q     <= '0;
            idx_q       <= '0;
            lane_q      <= '0;
            log_q       <= '0;
            busy        <= 1'b0;
            update_done <= 1'b0;
        end else begin
            state_q     <= state_d;
            frame_q     <= frame_d;
            idx_q       <= idx_d;
            lane_q      <= lane_d;
            log_q       <= log_d;
            busy        <= busy_d;
            update_done <= done_d;
        end
    end

    // Next-state logic; restart overrides everything, including an in-flight sweep
    always_comb begin
        state_d = state_q;
        frame_d = frame_q;
        idx_d   = idx_q;
        lane_d  = lane_q;
        log_d   = log_q;
        busy_d  = 1'b0;
        done_d  = 1'b0;
        wr_en_c = 1'b0;
        case (state_q)
            IDLE: begin
                if (startOfFrame && enable) begin
                    if (frame_q == FRM_W'(FRAME_DIV - 1)) begin
                        frame_d = '0;
                        idx_d   = '0;
                        lane_d  = '0;
                        log_d   = '0;
                        state_d = SWEEP;
                    end else begin
                        frame_d = frame_q + FRM_W'(1);
                    end
                end
            end
            SWEEP: begin
                busy_d  = 1'b1;
                wr_en_c = 1'b1;
                idx_d   = idx_q + IDX_W'(1);
                if (log_q == LOG_W'(LOGS_PER_LANE - 1)) begin
                    log_d  = '0;
                    lane_d = lane_q + LANE_W'(1);
                end else begin
                    log_d  = log_q + LOG_W'(1);
                end
                if (idx_q == IDX_W'(NUM_ACTIVE - 1)) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                done_d  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        if (restart) begin
            state_d = IDLE;
            frame_d = '0;
            idx_d   = '0;
            lane_d  = '0;
            log_d   = '0;
            busy_d  = 1'b0;
            done_d  = 1'b0;
            wr_en_c = 1'b0;
        end
    end

    // Wrapped position for the slot being swept; even lanes move right, odd lanes left
    always_comb begin
        step_c = ARI_W'(1) + ARI_W'(lane_q % 3) + ARI_W'(level);
        cur_c  = ARI_W'(pos_x[idx_q]);
        sum_c  = cur_c + step_c;
        if (!lane_q[0]) begin
            x_new_c = (sum_c >= ARI_W'(SCREEN_W)) ? sum_c - ARI_W'(SCREEN_W) : sum_c;
        end else begin
            x_new_c = (cur_c < step_c) ? cur_c + ARI_W'(SCREEN_W) - step_c : cur_c - step_c;
        end
    end

    // Position storage; Y is only ever (re)loaded
    always_ff @(posedge CLK or negedge RESETn) begin
        if (!RESETn) begin
            for (int unsigned i = 0; i < NUM_ACTIVE; i++) begin
                pos_x[i] <= init_x(i);
                pos_y[i] <= init_y(i);
            end
        end else if (restart) begin
            for (int unsigned i = 0; i < NUM_ACTIVE; i++) begin
                pos_x[i] <= init_x(i);
                pos_y[i] <= init_y(i);
            end
        end else if (wr_en_c) begin
            for (int unsigned i = 0; i < NUM_ACTIVE; i++) begin
                if (idx_q == IDX_W'(i)) begin
                    pos_x[i] <= x_new_c[POS_W-1:0];
                end
            end
        end
    end

    // Unused slots park at Y = 2047 so their end-Y wraps off-screen
    for (genvar i = 0; i < OUT_SLOTS; i++) begin : g_out
        if (i < NUM_ACTIVE) begin : g_act
            assign ObjectStartX[i] = pos_x[i];
            assign ObjectStartY[i] = pos_y[i];
        end else begin : g_unused
            assign ObjectStartX[i] = '0;
            assign ObjectStartY[i] = 11'h7FF;
        end
    end

endmodule
